fetch_mem_sequencer: RTL
========================

Name: fetch_mem_sequencer

Overview:
- Sequences all traffic into the unified 256 x 5-bit data/instruction memory of the multi-cycle CPU. The memory has a combinational 20-bit read and a synchronous write of an 8-bit value, zero-extended to 20 bits.
- Owns the PC and the instruction register. Fetches 20-bit words, hands them to decode through a valid/ready handshake, and performs one data load or store per instruction on request from execute.
- Sits directly upstream of the memory: it drives the memory address, write-enable and write data, and consumes the memory read word.

Parameters:
- ADDR_W, 8, memory byte-address width.
- WORD_W, 20, instruction/read word width (4 x 5-bit cells).
- DATA_W, 8, store data width.
- PC_STEP, 4, PC increment per fetch.
- RESET_PC, 0, PC value after reset.
- MAX_ADDR, 252, highest legal word address (ADD+3 must be at most 255).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; leaves IDLE when high.
- ADD  out  ADDR_W  memory address.
- mem_write  out  1  memory write enable.
- WD  out  DATA_W  memory write data.
- RD  in  WORD_W  memory read word (combinational from ADD).
- instr  out  WORD_W  instruction register.
- instr_valid  out  1  instr holds an unaccepted instruction.
- instr_ready  in  1  decode accepts instr.
- branch_valid  in  1  load PC from branch_target (sampled in EXEC only).
- branch_target  in  ADDR_W  new PC.
- data_req  in  1  data access request (sampled in EXEC only).
- data_we  in  1  1 = store, 0 = load.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  store data.
- data_rdata  out  WORD_W  registered load result.
- data_done  out  1  one-cycle pulse when a data access completes.
- pc  out  ADDR_W  current PC.
- addr_err  out  1  sticky: an access with address > MAX_ADDR was suppressed.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, pc = RESET_PC.
  - instr, data_rdata = 0; instr_valid, data_done, addr_err = 0.
  - mem_write is gated by !reset, so no write can occur on a reset edge, including reset during DATA.
- States: IDLE, FETCH, HOLD, EXEC, DATA.
- IDLE:
  - ADD = pc, mem_write = 0.
  - start = 1 -> FETCH.
- FETCH:
  - ADD = pc.
  - If pc <= MAX_ADDR: at the edge instr <= RD, pc <= pc + PC_STEP (mod 256, so 252 -> 0), instr_valid <= 1, next HOLD.
  - If pc > MAX_ADDR: addr_err <= 1, instr unchanged, next IDLE.
- HOLD:
  - instr_valid = 1, and instr stays stable until accepted.
  - instr_ready = 1 -> instr_valid <= 0, next EXEC.
  - Fetch latency: instr_valid rises 1 cycle after entering FETCH.
- EXEC (exactly one cycle):
  - branch_valid = 1 -> pc <= branch_target.
  - data_req = 1 -> latch data_addr, data_we and data_wdata into internal regs; next DATA.
  - Otherwise next FETCH.
  - branch_valid and data_req together: both are honoured; the data access uses data_addr, and the following fetch uses branch_target.
- DATA:
  - ADD = latched data address.
  - Store: mem_write = 1 for this single cycle, WD = latched data.
  - Load: data_rdata <= RD at the edge.
  - data_done <= 1 (high for the following cycle only), next FETCH.
  - If the latched address > MAX_ADDR: mem_write is forced to 0, data_rdata <= 0, addr_err <= 1; data_done still pulses.
- Outside DATA: mem_write = 0 and WD = 0.
- Inputs in other states:
  - data_req and branch_valid are ignored outside EXEC.
  - instr_ready is ignored outside HOLD.
- addr_err clears only on reset.

Decomposition:
- Shared package cpu_mem_pkg:
  - state enum (IDLE, FETCH, HOLD, EXEC, DATA).
  - ADDR_W, WORD_W, DATA_W, MAX_ADDR, PC_STEP.
- One natural sub-module: pc_reg (pc register with load/increment/reset, wrap mod 256).
- The FSM and the access mux stay in the top module.

Test Plan:
- Reset, start = 1, memory word at 0 = 20'hE0208, instr_ready = 1 -> instr = 20'hE0208 with instr_valid high in cycle 2; then pc = 4.
- Hold instr_ready = 0 for 5 cycles -> instr stable, instr_valid high, no new fetch, pc stays 4.
- EXEC with data_req = 1, data_we = 1, data_addr = 8'h40, data_wdata = 8'h5A -> mem_write high for exactly one cycle with ADD = 8'h40, WD = 8'h5A; readback via a load gives data_rdata = 20'h0005A and data_done pulses once.
- EXEC with branch_valid = 1, branch_target = 8'h10 and data_req (load from 8'h20) in the same cycle -> load from 8'h20 completes first, next fetch ADD = 8'h10.
- pc = 252 fetch -> pc wraps to 0.
- branch_target = 8'hFE -> fetch suppressed, addr_err = 1, FSM returns to IDLE.
- Assert reset during a DATA store cycle -> no memory write occurs; all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared widths, limits, FSM state type and address check for the fetch/memory sequencer.
package cpu_mem_pkg;
    localparam int ADDR_W = 8;
    localparam int WORD_W = 20;
    localparam int DATA_W = 8;
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(252);
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(0);

    typedef enum logic [2:0] {IDLE, FETCH, HOLD, EXEC, DATA} state_e;

    // A 20-bit word spans four cells, so the last legal word start is MAX_ADDR.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return a <= MAX_ADDR;
    endfunction
endpackage

// File: rtl/fetch_mem_sequencer_if.sv
// fetch_mem_sequencer_if: memory bus, decode handshake and execute request signals.
//   master: the sequencer (drives ADD/mem_write/WD, instr/instr_valid, data_rdata/data_done, pc, addr_err)
//   slave : memory + decode + execute side (drives start, RD, instr_ready, branch_*, data_*)
interface fetch_mem_sequencer_if;
    import cpu_mem_pkg::*;
    logic              start;
    logic [ADDR_W-1:0] ADD;
    logic              mem_write;
    logic [DATA_W-1:0] WD;
    logic [WORD_W-1:0] RD;
    logic [WORD_W-1:0] instr;
    logic              instr_valid;
    logic              instr_ready;
    logic              branch_valid;
    logic [ADDR_W-1:0] branch_target;
    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [WORD_W-1:0] data_rdata;
    logic              data_done;
    logic [ADDR_W-1:0] pc;
    logic              addr_err;

    modport master (
        input  start, RD, instr_ready, branch_valid, branch_target,
               data_req, data_we, data_addr, data_wdata,
        output ADD, mem_write, WD, instr, instr_valid, data_rdata, data_done, pc, addr_err
    );
    modport slave (
        output start, RD, instr_ready, branch_valid, branch_target,
               data_req, data_we, data_addr, data_wdata,
        input  ADD, mem_write, WD, instr, instr_valid, data_rdata, data_done, pc, addr_err
    );
endinterface

// File: rtl/pc_reg.sv
// pc_reg: program counter with branch load, fetch increment (wraps mod 256) and sync reset.
//   clk, reset : clock, synchronous active-high reset
//   load_i     : load load_val_i (takes priority over inc_i)
//   inc_i      : advance by PC_STEP
//   pc_o       : current PC
module pc_reg
    import cpu_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] load_val_i,
    output logic [ADDR_W-1:0] pc_o
);
    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb pc_d = load_i ? load_val_i : inc_i ? pc_q + PC_STEP : pc_q;

    always_ff @(posedge clk) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/fetch_mem_sequencer.sv
// fetch_mem_sequencer: multi-cycle fetch / hold / exec / data sequencer in front of the unified memory.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_mem_sequencer_if.master (memory port, decode handshake, execute data/branch requests)
module fetch_mem_sequencer
    import cpu_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    fetch_mem_sequencer_if.master bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc, daddr_q;
    logic              dwe_q;
    logic [DATA_W-1:0] dwdata_q;
    logic [WORD_W-1:0] instr_q, rdata_q;
    logic              valid_q, done_q, err_q;
    logic              pc_load, pc_inc, latch, pc_ok, d_ok;

    assign pc_ok = addr_ok(pc);
    assign d_ok  = addr_ok(daddr_q);

    pc_reg u_pc (
        .clk        (clk),
        .reset      (reset),
        .load_i     (pc_load),
        .inc_i      (pc_inc),
        .load_val_i (bus.branch_target),
        .pc_o       (pc)
    );

    always_comb begin
        state_d       = state_q;
        bus.ADD       = pc;
        bus.mem_write = 1'b0;
        bus.WD        = '0;
        pc_load       = 1'b0;
        pc_inc        = 1'b0;
        latch         = 1'b0;
        case (state_q)
            IDLE:  state_d = bus.start ? FETCH : IDLE;
            FETCH: begin
                pc_inc  = pc_ok;
                state_d = pc_ok ? HOLD : IDLE;
            end
            HOLD:  state_d = bus.instr_ready ? EXEC : HOLD;
            EXEC: begin
                pc_load = bus.branch_valid;
                latch   = bus.data_req;
                state_d = bus.data_req ? DATA : FETCH;
            end
            DATA: begin
                bus.ADD       = daddr_q;
                bus.WD        = dwdata_q;
                // gated by reset so a reset edge landing in DATA never writes
                bus.mem_write = dwe_q && d_ok && !reset;
                state_d       = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            daddr_q  <= '0;
            dwe_q    <= 1'b0;
            dwdata_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= state_q == DATA;
            if (state_q == FETCH) begin
                if (pc_ok) begin
                    instr_q <= bus.RD;
                    valid_q <= 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (state_q == HOLD && bus.instr_ready) valid_q <= 1'b0;
            if (latch) begin
                daddr_q  <= bus.data_addr;
                dwe_q    <= bus.data_we;
                dwdata_q <= bus.data_wdata;
            end
            if (state_q == DATA) begin
                if (!d_ok) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end else if (!dwe_q) begin
                    rdata_q <= bus.RD;
                end
            end
        end
    end

    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.data_rdata  = rdata_q;
    assign bus.data_done   = done_q;
    assign bus.pc          = pc;
    assign bus.addr_err    = err_q;
endmodule
